// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Purpose:
//   Restoring radix-2 sequential divider that is sized to pair with the 8x8
//   multiplier. It divides a 16-bit unsigned dividend by an 8-bit unsigned
//   divisor and produces one quotient bit per clock. It steps through IDLE,
//   16 BUSY iterations, and one DONE cycle. A zero divisor skips the
//   iterations and reports an all-ones quotient with the dbz flag set.
//
// Ports:
//   clk        in   1   single clock; all state changes on the rising edge
//   rst        in   1   synchronous active-high reset
//   start      in   1   division request; only looked at in IDLE
//   dividend   in  16   unsigned dividend, captured on the accepted start
//   divisor    in   8   unsigned divisor, captured on the accepted start
//   quotient   out 16   registered quotient of the most recent result
//   remainder  out  8   registered remainder of the most recent result
//   busy       out  1   high while the iterations are running
//   done       out  1   one-cycle pulse when a new result is presented
//   dbz        out  1   divide-by-zero flag of the most recent result
// ---------------------------------------------------------------------------
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Working registers. dvd_q starts out holding the dividend. Each
    // iteration shifts the dividend's top bit out into the partial
    // remainder and shifts a quotient bit in at the bottom. After 16
    // iterations it holds the quotient.
    logic [16:0] part_rem;
    logic [15:0] dvd_q;
    logic [7:0]  dsr;
    logic [4:0]  count;

    logic [16:0] shifted;
    logic [17:0] trial;
    logic        q_bit;
    logic [16:0] rem_next;
    logic [15:0] dvd_q_next;
    logic        last_iter;

    // One restoring step. The trial subtraction is one bit wider so its
    // sign bit tells whether the divisor fits. A set bit shifted out of
    // the partial remainder's MSB means the value certainly exceeds any
    // 8-bit divisor, so that bit also forces the subtraction to be kept.
    always_comb begin
        shifted    = {part_rem[15:0], dvd_q[15]};
        trial      = {1'b0, shifted} - {10'd0, dsr};
        q_bit      = part_rem[16] | ~trial[17];
        rem_next   = q_bit ? trial[16:0] : shifted;
        dvd_q_next = {dvd_q[14:0], q_bit};
        last_iter  = (count == 5'd15);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero divisor goes straight to DONE because its
    // result is fixed. DONE always falls back to IDLE, so a start held
    // high gives one division every 18 cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == 8'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. The result registers are written only when a result is
    // final: on a zero-divisor start or on the last iteration. They
    // therefore keep the previous answer while the iterations run.
    // Operands are captured only on an accepted start, so later input
    // changes have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            part_rem  <= 17'd0;
            dvd_q     <= 16'd0;
            dsr       <= 8'd0;
            count     <= 5'd0;
            quotient  <= 16'd0;
            remainder <= 8'd0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        part_rem <= 17'd0;
                        count    <= 5'd0;
                        dvd_q    <= dividend;
                        dsr      <= divisor;
                        if (divisor == 8'd0) begin
                            quotient  <= 16'hFFFF;
                            remainder <= dividend[7:0];
                            dbz       <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    part_rem <= rem_next;
                    dvd_q    <= dvd_q_next;
                    count    <= count + 5'd1;
                    if (last_iter) begin
                        quotient  <= dvd_q_next;
                        remainder <= rem_next[7:0];
                        dbz       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Self-checking bench for seq_divider. A table of directed vectors runs
// first. It is followed by hand-written sequences for reset during a
// division and for back-to-back starts. Randomised operands and
// multiply/divide round trips then run against an arithmetic reference
// (a / b, a % b).
// ---------------------------------------------------------------------------
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        dbz;

    int vectors;
    int miscompares;

    // Last result the bench expects the DUT to be holding.
    logic [15:0] last_q;
    logic [7:0]  last_r;
    logic        last_dbz;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } vec_t;

    vec_t vecs[9];

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the bench can never hang.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one value and records the result.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Presents operands with start for exactly one edge, then scrambles
    // the operand inputs. The scrambled values must not affect the result.
    // Returns at the falling edge just after the start edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Runs one division and checks the following:
    //   - latency: 1 cycle for a zero divisor, 17 cycles otherwise
    //   - the final result
    //   - that the old result is held while the division runs
    //   - that start pulses during BUSY and during DONE are ignored
    task automatic runCheck(input string tag, input logic [15:0] a,
                            input logic [7:0] b, input logic [15:0] eq,
                            input logic [7:0] er, input logic ez);
        int   lat;
        int   elat;
        logic held;
        elat = (b == 8'd0) ? 1 : 17;
        applyStimulus(a, b);
        checkOutput({tag, "_busy_first"}, 32'(busy), 32'(b != 8'd0));
        lat  = 1;
        held = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (quotient !== last_q || remainder !== last_r || dbz !== last_dbz)
                held = 1'b0;
            start = (lat == 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(elat));
        checkOutput({tag, "_hold_busy"}, 32'(held), 32'd1);
        checkOutput({tag, "_quotient"}, 32'(quotient), 32'(eq));
        checkOutput({tag, "_remainder"}, 32'(remainder), 32'(er));
        checkOutput({tag, "_dbz"}, 32'(dbz), 32'(ez));
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
        last_q   = eq;
        last_r   = er;
        last_dbz = ez;
        // Poke start during DONE. It must be ignored, and the machine
        // must return to IDLE with the result held.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_no_restart"}, 32'(busy), 32'd0);
        checkOutput({tag, "_hold_idle"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        dividend    = 16'd0;
        divisor     = 8'd0;
        last_q      = 16'd0;
        last_r      = 8'd0;
        last_dbz    = 1'b0;

        vecs[0] = '{a: 16'd2300,  b: 8'd23,  q: 16'd100,   r: 8'd0,   z: 1'b0};
        vecs[1] = '{a: 16'd65535, b: 8'd255, q: 16'd257,   r: 8'd0,   z: 1'b0};
        vecs[2] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,   z: 1'b0};
        vecs[3] = '{a: 16'd5,     b: 8'd7,   q: 16'd0,     r: 8'd5,   z: 1'b0};
        vecs[4] = '{a: 16'd2301,  b: 8'd23,  q: 16'd100,   r: 8'd1,   z: 1'b0};
        vecs[5] = '{a: 16'd65535, b: 8'd2,   q: 16'd32767, r: 8'd1,   z: 1'b0};
        vecs[6] = '{a: 16'd0,     b: 8'd5,   q: 16'd0,     r: 8'd0,   z: 1'b0};
        vecs[7] = '{a: 16'h03E8,  b: 8'd0,   q: 16'hFFFF,  r: 8'hE8,  z: 1'b1};
        vecs[8] = '{a: 16'd2300,  b: 8'd23,  q: 16'd100,   r: 8'd0,   z: 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dbz", 32'(dbz), 32'd0);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            runCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                     vecs[i].q, vecs[i].r, vecs[i].z);
        end

        // Reset in the middle of a division: it must produce no done
        // pulse and must clear the held result (dbz=1 before the reset).
        runCheck("dbz_pre", 16'h03E8, 8'd0, 16'hFFFF, 8'hE8, 1'b1);
        begin
            logic no_done;
            no_done = 1'b1;
            @(negedge clk);
            dividend = 16'd2300;
            divisor  = 8'd23;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                if (k == 5) begin
                    start    = 1'b1;
                    dividend = 16'h1234;
                    divisor  = 8'd0;
                end else begin
                    start = 1'b0;
                end
                if (k == 10) rst = 1'b1;
                @(negedge clk);
                if (done === 1'b1) no_done = 1'b0;
            end
            start = 1'b0;
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_done", 32'(done), 32'd0);
            checkOutput("abort_dbz", 32'(dbz), 32'd0);
            checkOutput("abort_quotient", 32'(quotient), 32'd0);
            checkOutput("abort_remainder", 32'(remainder), 32'd0);
            rst = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done === 1'b1) no_done = 1'b0;
            end
            checkOutput("abort_no_done", 32'(no_done), 32'd1);
            last_q   = 16'd0;
            last_r   = 8'd0;
            last_dbz = 1'b0;
        end
        runCheck("after_abort", 16'd2300, 8'd23, 16'd100, 8'd0, 1'b0);

        // With start held high, divisions run back to back with an
        // 18-cycle period.
        begin
            int n;
            int m;
            @(negedge clk);
            dividend = 16'd2300;
            divisor  = 8'd23;
            start    = 1'b1;
            n = 0;
            while (done !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            checkOutput("b2b_first_latency", 32'(n), 32'd17);
            m = 0;
            do begin
                @(negedge clk);
                m++;
            end while (done !== 1'b1 && m < 60);
            checkOutput("b2b_period", 32'(m), 32'd18);
            checkOutput("b2b_quotient", 32'(quotient), 32'd100);
            checkOutput("b2b_remainder", 32'(remainder), 32'd0);
            start = 1'b0;
            repeat (2) @(negedge clk);
            checkOutput("b2b_stop", 32'(busy), 32'd0);
            last_q   = 16'd100;
            last_r   = 8'd0;
            last_dbz = 1'b0;
        end

        // Random non-zero divisors against the arithmetic reference.
        for (int i = 0; i < 1500; i++) begin
            int unsigned a;
            int unsigned b;
            a = $urandom_range(0, 65535);
            b = $urandom_range(1, 255);
            runCheck("rand", 16'(a), 8'(b), 16'(a / b), 8'(a % b), 1'b0);
            checkOutput("rand_identity",
                        32'(quotient) * b + 32'(remainder), a);
            checkOutput("rand_rem_lt", 32'(32'(remainder) < b), 32'd1);
        end

        // Multiply/divide round trip: (x*y)/y must give x with remainder 0.
        for (int i = 0; i < 500; i++) begin
            int unsigned x;
            int unsigned y;
            x = $urandom_range(0, 255);
            y = $urandom_range(1, 255);
            runCheck("roundtrip", 16'(x * y), 8'(y), 16'(x), 8'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
